// File: rtl/bus_dma_initiator_if.sv
// Shared 32-bit memory/peripheral bus as seen by a bus initiator, plus the arbiter grant.
// master = the initiator driving strobes; slave = responders/arbiter side.
interface bus_dma_initiator_if;
  logic        o_bus_stb;
  logic        o_bus_we;
  logic [31:0] o_bus_addr;
  logic [31:0] o_bus_data;
  logic [31:0] i_bus_data;
  logic        i_bus_data_ready;
  logic        i_grant;

  modport master (
    output o_bus_stb, o_bus_we, o_bus_addr, o_bus_data,
    input  i_bus_data, i_bus_data_ready, i_grant
  );

  modport slave (
    input  o_bus_stb, o_bus_we, o_bus_addr, o_bus_data,
    output i_bus_data, i_bus_data_ready, i_grant
  );
endinterface

// File: rtl/bus_dma_initiator.sv
// Bus-initiator copy engine: per word, one read beat from src then one write beat to dst.
// Every new strobe waits for the arbiter grant; reads time out after TIMEOUT cycles.
module bus_dma_initiator #(
  parameter int unsigned ADDR_STEP = 1,
  parameter int unsigned TIMEOUT   = 255,
  parameter int unsigned LEN_W     = 16
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_start,
  input  logic                 i_abort,
  input  logic [31:0]          i_src,
  input  logic [31:0]          i_dst,
  input  logic [LEN_W-1:0]     i_len,
  bus_dma_initiator_if.master  bus,
  output logic                 o_busy,
  output logic                 o_done,
  output logic                 o_error,
  output logic [LEN_W-1:0]     o_count
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_G,
    S_RD,
    S_WR,
    S_GAP,
    S_DONE
  } state_t;

  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);
  localparam logic [31:0] STEP     = 32'(ADDR_STEP);

  state_t      state;
  logic [31:0] src_ptr;
  logic [31:0] dst_ptr;
  logic [15:0] timer;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state          <= S_IDLE;
      src_ptr        <= '0;
      dst_ptr        <= '0;
      timer          <= '0;
      bus.o_bus_stb  <= 1'b0;
      bus.o_bus_we   <= 1'b0;
      bus.o_bus_addr <= '0;
      bus.o_bus_data <= '0;
      o_busy         <= 1'b0;
      o_done         <= 1'b0;
      o_error        <= 1'b0;
      o_count        <= '0;
    end else begin
      o_done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (i_start) begin
            src_ptr <= i_src;
            dst_ptr <= i_dst;
            o_count <= i_len;
            o_busy  <= 1'b1;
            o_error <= 1'b0;
            timer   <= '0;
            if (i_len == '0) begin
              o_done <= 1'b1;
              state  <= S_DONE;
            end else begin
              state  <= S_WAIT_G;
            end
          end
        end

        S_WAIT_G: begin
          if (i_abort) begin
            o_error <= 1'b1;
            o_done  <= 1'b1;
            state   <= S_DONE;
          end else if (bus.i_grant) begin
            bus.o_bus_stb  <= 1'b1;
            bus.o_bus_we   <= 1'b0;
            bus.o_bus_addr <= src_ptr;
            timer          <= '0;
            state          <= S_RD;
          end
        end

        // Abort outranks a same-cycle ready; ready outranks the final timeout cycle.
        S_RD: begin
          if (i_abort || (!bus.i_bus_data_ready && timer == TMO_LAST)) begin
            bus.o_bus_stb <= 1'b0;
            timer         <= '0;
            o_error       <= 1'b1;
            o_done        <= 1'b1;
            state         <= S_DONE;
          end else if (bus.i_bus_data_ready) begin
            bus.o_bus_data <= bus.i_bus_data;
            bus.o_bus_we   <= 1'b1;
            bus.o_bus_addr <= dst_ptr;
            timer          <= '0;
            state          <= S_WR;
          end else begin
            timer <= timer + 16'd1;
          end
        end

        // Pointer/count update happens as the write retires, so GAP already
        // shows the decremented count and an abort here still accounts the word.
        S_WR: begin
          bus.o_bus_stb <= 1'b0;
          bus.o_bus_we  <= 1'b0;
          src_ptr       <= src_ptr + STEP;
          dst_ptr       <= dst_ptr + STEP;
          o_count       <= o_count - LEN_W'(1);
          if (i_abort) begin
            o_error <= 1'b1;
            o_done  <= 1'b1;
            state   <= S_DONE;
          end else begin
            state   <= S_GAP;
          end
        end

        S_GAP: begin
          if (i_abort) begin
            o_error <= 1'b1;
            o_done  <= 1'b1;
            state   <= S_DONE;
          end else if (o_count == '0) begin
            o_done <= 1'b1;
            state  <= S_DONE;
          end else begin
            state  <= S_WAIT_G;
          end
        end

        S_DONE: begin
          o_busy <= 1'b0;
          state  <= S_IDLE;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
